// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction prefetch queue.
//   DEFAULT_DEPTH    : default occupancy bound (queue entries + in-flight)
//   NOP_INSTR        : instruction presented when the queue is empty
//   prefetch_state_t : S_BOOT / S_RUN / S_FLUSH
//   fetch_entry_t    : one queued instruction with its pc
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int          DEFAULT_DEPTH = 4;
   localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } prefetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue_if
// Bundles the redirect, instruction-memory and IF/ID handshake signals.
//   slave  : prefetch queue view (drives requests and the instruction output)
//   master : environment view (memory, redirect source and IF/ID consumer)
// -----------------------------------------------------------------------------
interface instr_prefetch_queue_if;

   logic [31:0] force_pc;
   logic        take_force_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   modport slave (
      input  force_pc, take_force_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, out_ready,
      output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
   );

   modport master (
      output force_pc, take_force_pc, imem_req_ready, imem_rsp_valid,
             imem_rsp_data, out_ready,
      input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
   );

endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with synchronous clear and an occupancy count.
//   clk, reset : clock, asynchronous active-low reset
//   i_clr      : empties the FIFO at the next edge (wins over push/pop)
//   i_push     : write i_wdata (accepted when not full, or full with a pop)
//   i_pop      : drop the head entry (ignored when empty)
//   o_rdata    : head entry (undefined content when empty)
//   o_count    : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_full;
   logic w_empty;
   logic w_do_push;
   logic w_do_pop;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_push = i_push && (!w_full || i_pop);
   assign w_do_pop  = i_pop && !w_empty;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // NOTE: storage has no reset; the count and pointers define validity, so
   // the array can map onto plain RAM/flops without a reset tree.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/instr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// instr_prefetch_queue
// Fetches sequential instruction words ahead of IF/ID and buffers them.
// Total occupancy (queued + in-flight requests) is bounded by DEPTH. A redirect
// empties the queue, reloads the fetch pc and discards every response of the
// requests still in flight.
//   clk, reset : clock, asynchronous active-low reset
//   bus        : instr_prefetch_queue_if.slave
//                force_pc/take_force_pc       redirect
//                imem_req_valid/ready/addr    fetch request
//                imem_rsp_valid/data          in-order fetch response
//                out_valid/ready/pc/instr     instruction to IF/ID
// Build option: PREFETCH_BYPASS_EN lets a response reach the output in the
// cycle it arrives when the queue is empty.
// -----------------------------------------------------------------------------
module instr_prefetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = DEFAULT_DEPTH,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   instr_prefetch_queue_if.slave  bus
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   prefetch_state_t r_state;
   logic [31:0]     r_fetch_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_drop_cnt;

   logic          w_req_valid;
   logic          w_fire;
   logic          w_rsp_acc;
   logic          w_rsp_keep;
   logic          w_bypass;
   logic          w_q_push;
   logic          w_q_pop;
   logic          w_q_empty;
   logic [CW-1:0] w_q_count;
   logic [CW-1:0] w_t_count;
   logic [CW-1:0] w_out_next;
   logic [31:0]   w_tag_head;
   logic [31:0]   w_out_pc;
   logic [31:0]   w_out_instr;
   fetch_entry_t  w_q_head;
   fetch_entry_t  w_q_wdata;

   assign w_req_valid = (r_state == S_RUN) &&
                        (({1'b0, w_q_count} + {1'b0, r_outstanding}) < DEPTH_W);
   assign w_fire      = w_req_valid && bus.imem_req_ready;
   // A response with nothing in flight is a protocol error and is ignored.
   assign w_rsp_acc   = bus.imem_rsp_valid && (r_outstanding != '0);
   // Only responses in S_RUN outside a redirect cycle carry live instructions.
   assign w_rsp_keep  = w_rsp_acc && (r_state == S_RUN) && !bus.take_force_pc &&
                        (w_t_count != '0);
   // In-flight count after this edge; also the number to drop on a redirect.
   assign w_out_next  = r_outstanding + CW'(w_fire) - CW'(w_rsp_acc);
   assign w_q_empty   = (w_q_count == '0);

`ifdef PREFETCH_BYPASS_EN
   assign w_bypass = w_rsp_keep && w_q_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign w_q_wdata = '{pc: w_tag_head, instr: bus.imem_rsp_data};
   assign w_q_pop   = !w_q_empty && bus.out_ready;
   assign w_q_push  = w_rsp_keep && !(w_bypass && bus.out_ready);

   // Pc tags of live requests, consumed in response order.
   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (bus.take_force_pc),
      .i_push  (w_fire),
      .i_wdata (r_fetch_pc),
      .i_pop   (w_rsp_keep),
      .o_rdata (w_tag_head),
      .o_count (w_t_count)
   );

   sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
      .clk     (clk),
      .reset   (reset),
      .i_clr   (bus.take_force_pc),
      .i_push  (w_q_push),
      .i_wdata (w_q_wdata),
      .i_pop   (w_q_pop),
      .o_rdata (w_q_head),
      .o_count (w_q_count)
   );

   // NOTE: every output of this block gets a value on every path, so no latch
   // is inferred.
   always_comb begin
      w_out_pc    = 32'h0000_0000;
      w_out_instr = NOP_INSTR;
      if (!w_q_empty) begin
         w_out_pc    = w_q_head.pc;
         w_out_instr = w_q_head.instr;
      end else if (w_bypass) begin
         w_out_pc    = w_tag_head;
         w_out_instr = bus.imem_rsp_data;
      end
   end

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_fetch_pc;
   assign bus.out_valid      = !w_q_empty || w_bypass;
   assign bus.out_pc         = w_out_pc;
   assign bus.out_instr      = w_out_instr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_BOOT;
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (bus.take_force_pc) begin
            r_fetch_pc <= bus.force_pc;
            r_drop_cnt <= w_out_next;
            r_state    <= (w_out_next != '0) ? S_FLUSH : S_RUN;
         end else begin
            if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
            case (r_state)
               S_BOOT:  r_state <= S_RUN;
               S_RUN:   ;
               S_FLUSH: begin
                  if (w_rsp_acc) begin
                     r_drop_cnt <= r_drop_cnt - 1'b1;
                     if (r_drop_cnt == CW'(1)) r_state <= S_RUN;
                  end
               end
               default: r_state <= S_BOOT;
            endcase
         end
      end
   end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, queue entries plus in-flight requests (power of 2, 2..16) SHALL bound total occupancy.
REQ-002 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 force_pc  input  32  redirect target.
REQ-006 take_force_pc  input  1  redirect strobe.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts request.
REQ-009 imem_req_addr  output  32  fetch address, word aligned.
REQ-010 imem_rsp_valid  input  1  in-order response valid, latency >= 1 cycle.
REQ-011 imem_rsp_data  input  32  fetched instruction.
REQ-012 out_valid  output  1  instruction available to IF/ID.
REQ-013 out_ready  input  1  IF/ID consumes.
REQ-014 out_pc  output  32  pc of head entry.
REQ-015 out_instr  output  32  instruction of head entry.

Function
REQ-016 FSM states SHALL be S_BOOT, S_RUN, S_FLUSH; reset enters S_BOOT; S_BOOT -> S_RUN unconditionally next cycle, no request issued in S_BOOT.
REQ-017 In S_RUN, imem_req_valid SHALL be 1 iff (queue count + outstanding) < DEPTH; imem_req_addr = fetch_pc.
REQ-018 Request fire (valid & ready) SHALL increment fetch_pc by 4 (mod 2^32 wrap) and outstanding by 1.
REQ-019 Each imem_rsp_valid not being dropped SHALL push {pc, instr} into queue, pc taken from an internal in-order pc tag FIFO; outstanding decrements.
REQ-020 Pop SHALL occur on out_valid & out_ready; push and pop in the same cycle with queue full SHALL be legal and keep count unchanged.
REQ-021 take_force_pc SHALL, in the same edge: clear queue, set fetch_pc = force_pc, set drop_cnt = outstanding + req_fire - rsp_valid, enter S_FLUSH if that value > 0 else S_RUN.
REQ-022 Response arriving in the redirect cycle SHALL be discarded; request fired in the redirect cycle SHALL be counted for dropping.
REQ-023 In S_FLUSH, imem_req_valid SHALL be 0; each imem_rsp_valid decrements drop_cnt without pushing; drop_cnt reaching 0 -> S_RUN.
REQ-024 Redirect while in S_FLUSH SHALL update fetch_pc and recompute drop_cnt per REQ-021.
REQ-025 Queue empty: out_valid = 0, out_pc = 0, out_instr = 32'h0000_0013 (NOP).
REQ-026 imem_rsp_valid with outstanding == 0 SHALL be ignored (protocol error, no state change).

Reset
REQ-027 Reset asserted SHALL immediately force: state S_BOOT, fetch_pc = RESET_PC, queue/tag FIFO empty, outstanding = 0, drop_cnt = 0, imem_req_valid = 0, out_valid = 0, out_pc = 0, out_instr = NOP.
REQ-028 Reset mid-operation SHALL abandon in-flight requests; responses before first post-reset request SHALL be ignored per REQ-026.

Configuration
REQ-029 Macro PREFETCH_BYPASS_EN defined: a non-dropped response arriving with queue empty SHALL drive out_valid/out_pc/out_instr combinationally that cycle and, if out_ready, SHALL not be enqueued.
REQ-030 Macro undefined: every response SHALL be enqueued; earliest out_valid is the cycle after the response.

Structure
REQ-031 Shared package fetch_pkg SHALL hold fetch_entry_t {pc, instr}, prefetch_state_t enum, NOP_INSTR constant, DEFAULT_DEPTH.
REQ-032 Queue and pc tag FIFO SHALL be instances of one sub-module sync_fifo (parameterised width/depth, count output).

Verification
REQ-033 Reset release, imem ready always, latency 1 -> requests 0x0,0x4,0x8,0xC; out_pc 0x0 valid cycle 3 (no bypass).
REQ-034 out_ready held 0, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid stays 0 until one pop.
REQ-035 Redirect to 0x100 with 2 outstanding -> queue cleared, next 2 responses dropped, next request addr 0x100, first out_pc 0x100.
REQ-036 Redirect same cycle as response and request fire -> that response dropped, drop_cnt = outstanding, no stale instr emitted.
REQ-037 fetch_pc 0xFFFF_FFFC fire -> next addr 0x0000_0000.
REQ-038 Reset asserted with 3 outstanding and full queue -> all outputs at reset values same cycle; late responses ignored; restart at RESET_PC.
